// File: rtl/draw_line.sv
// Bresenham line rasteriser: latches two endpoints on start and emits one pixel per accepted cycle.
// Optional on-screen clipping is enabled by defining DRAW_LINE_CLIP_EN.
module draw_line #(
  parameter logic [9:0] H_MAX = 10'd639,
  parameter logic [9:0] V_MAX = 10'd479
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       draw_line_start,
  input  logic [9:0] x0,
  input  logic [9:0] y0,
  input  logic [9:0] x1,
  input  logic [9:0] y1,
  input  logic       pixel_ready,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       pixel_valid,
  output logic       draw_line_done
);

  typedef enum logic [1:0] {ST_WAIT, ST_INIT, ST_DRAW, ST_DONE} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [9:0]         r_x0, r_y0, r_x1, r_y1;
  logic [9:0]         r_cur_x, r_cur_y;
  logic signed [10:0] r_dx, r_dy;
  logic               r_sx_neg, r_sy_neg;
  logic signed [11:0] r_err;

  logic [10:0]        w_adx, w_ady;
  logic signed [12:0] w_e2, w_dx13, w_dy13;
  logic signed [11:0] w_dx12, w_dy12, w_err_nxt;
  logic               w_step_x, w_step_y;
  logic               w_at_end, w_in_draw, w_accept, w_offscreen;

  assign w_adx = (r_x1 >= r_x0) ? {1'b0, r_x1 - r_x0} : {1'b0, r_x0 - r_x1};
  assign w_ady = (r_y1 >= r_y0) ? {1'b0, r_y1 - r_y0} : {1'b0, r_y0 - r_y1};

  assign w_e2     = {r_err, 1'b0};
  assign w_dx13   = {{2{r_dx[10]}}, r_dx};
  assign w_dy13   = {{2{r_dy[10]}}, r_dy};
  assign w_dx12   = {r_dx[10], r_dx};
  assign w_dy12   = {r_dy[10], r_dy};
  assign w_step_x = (w_e2 >= w_dy13);
  assign w_step_y = (w_e2 <= w_dx13);
  assign w_err_nxt = r_err + (w_step_x ? w_dy12 : 12'sd0) + (w_step_y ? w_dx12 : 12'sd0);

  assign w_at_end    = (r_cur_x == r_x1) && (r_cur_y == r_y1);
  assign w_in_draw   = (r_state == ST_DRAW);
  assign w_offscreen = (r_cur_x > H_MAX) || (r_cur_y > V_MAX);

`ifdef DRAW_LINE_CLIP_EN
  // Off-screen points are skipped silently so the walk never waits on the frame buffer.
  assign w_accept    = pixel_ready || w_offscreen;
  assign pixel_valid = w_in_draw && !w_offscreen;
`else
  assign w_accept    = pixel_ready;
  assign pixel_valid = w_in_draw;

  a_on_screen: assert property (@(posedge Clk) disable iff (!Reset_n) w_in_draw |-> !w_offscreen);
`endif

  assign DrawX          = r_cur_x;
  assign DrawY          = r_cur_y;
  assign draw_line_done = (r_state == ST_DONE);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_WAIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_WAIT: if (draw_line_start) w_state_nxt = ST_INIT;
      ST_INIT: w_state_nxt = ST_DRAW;
      ST_DRAW: if (w_accept && w_at_end) w_state_nxt = ST_DONE;
      ST_DONE: if (!draw_line_start) w_state_nxt = ST_WAIT;
      default: w_state_nxt = ST_WAIT;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_x0     <= '0;
      r_y0     <= '0;
      r_x1     <= '0;
      r_y1     <= '0;
      r_cur_x  <= '0;
      r_cur_y  <= '0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_sx_neg <= 1'b0;
      r_sy_neg <= 1'b0;
      r_err    <= '0;
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (draw_line_start) begin
            r_x0 <= x0;
            r_y0 <= y0;
            r_x1 <= x1;
            r_y1 <= y1;
          end
        end
        ST_INIT: begin
          r_dx     <= $signed(w_adx);
          r_dy     <= -$signed(w_ady);
          r_sx_neg <= !(r_x0 < r_x1);
          r_sy_neg <= !(r_y0 < r_y1);
          r_err    <= $signed({1'b0, w_adx}) - $signed({1'b0, w_ady});
          r_cur_x  <= r_x0;
          r_cur_y  <= r_y0;
        end
        ST_DRAW: begin
          // The final point is consumed without stepping, so coordinates never leave the segment.
          if (w_accept && !w_at_end) begin
            if (w_step_x) r_cur_x <= r_cur_x + (r_sx_neg ? 10'h3FF : 10'h001);
            if (w_step_y) r_cur_y <= r_cur_y + (r_sy_neg ? 10'h3FF : 10'h001);
            r_err <= w_err_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_line.sv
// Randomised self-checking bench for draw_line against a queue-based Bresenham reference.
module tb_draw_line;

`ifdef DRAW_LINE_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       draw_line_start;
  logic [9:0] x0, y0, x1, y1;
  logic       pixel_ready;
  logic [9:0] DrawX, DrawY;
  logic       pixel_valid;
  logic       draw_line_done;

  int n_checks = 0;
  int n_errors = 0;

  logic [19:0] exp_q[$];

  draw_line dut (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .draw_line_start(draw_line_start),
    .x0             (x0),
    .y0             (y0),
    .x1             (x1),
    .y1             (y1),
    .pixel_ready    (pixel_ready),
    .DrawX          (DrawX),
    .DrawY          (DrawY),
    .pixel_valid    (pixel_valid),
    .draw_line_done (draw_line_done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Textbook Bresenham walk producing the full list of visible points in order.
  task automatic build_model(input int ax0, input int ay0, input int ax1, input int ay1);
    int dx, dy, sx, sy, err, e2, x, y;
    exp_q.delete();
    dx  = iabs(ax1 - ax0);
    dy  = -iabs(ay1 - ay0);
    sx  = (ax0 < ax1) ? 1 : -1;
    sy  = (ay0 < ay1) ? 1 : -1;
    err = dx + dy;
    x   = ax0;
    y   = ay0;
    for (int k = 0; k < 2000; k++) begin
      if (!CLIP || (x <= 639 && y <= 479)) exp_q.push_back({10'(x), 10'(y)});
      if (x == ax1 && y == ay1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  // mode 0: ready always high, 1: random ready, 2: ready low on draw cycles 2..4
  task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1, input int mode);
    int n_exp, full_len, cyc, idx, first_valid, last_acc, done_cyc, vcnt;
    logic pv_prev, rd_prev;
    logic [9:0] px_prev, py_prev;
    bit end_visible, start_visible;
    build_model(ax0, ay0, ax1, ay1);
    n_exp         = exp_q.size();
    full_len      = ((iabs(ax1 - ax0) > iabs(ay1 - ay0)) ? iabs(ax1 - ax0) : iabs(ay1 - ay0)) + 1;
    end_visible   = (ax1 <= 639) && (ay1 <= 479);
    start_visible = (ax0 <= 639) && (ay0 <= 479);
    cyc = 0; idx = 0; first_valid = -1; last_acc = -1; done_cyc = -1; vcnt = 0;
    pv_prev = 1'b0; rd_prev = 1'b1; px_prev = '0; py_prev = '0;

    @(negedge Clk);
    x0 = 10'(ax0); y0 = 10'(ay0); x1 = 10'(ax1); y1 = 10'(ay1);
    draw_line_start = 1'b1;
    pixel_ready     = 1'b1;

    while (cyc < 3000 && done_cyc < 0) begin
      @(negedge Clk);
      cyc++;
      x0 = 10'($urandom_range(0, 1023)); y0 = 10'($urandom_range(0, 1023));
      x1 = 10'($urandom_range(0, 1023)); y1 = 10'($urandom_range(0, 1023));
      if (pv_prev && !rd_prev) begin
        check("stall_valid", pixel_valid, 1);
        check("stall_x", DrawX, px_prev);
        check("stall_y", DrawY, py_prev);
      end
      if (pixel_valid) vcnt++;
      case (mode)
        1:       pixel_ready = ($urandom_range(0, 3) != 0);
        2:       pixel_ready = !(pixel_valid && vcnt >= 2 && vcnt <= 4);
        default: pixel_ready = 1'b1;
      endcase
      if (draw_line_done) begin
        done_cyc = cyc;
        check("done_valid", pixel_valid, 0);
      end else if (pixel_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (idx < n_exp) begin
          check("pix_x", DrawX, exp_q[idx][19:10]);
          check("pix_y", DrawY, exp_q[idx][9:0]);
        end else begin
          check("extra_pix", idx + 1, n_exp);
        end
        if (pixel_ready) begin
          idx++;
          last_acc = cyc;
        end
      end
      pv_prev = pixel_valid; rd_prev = pixel_ready;
      px_prev = DrawX;       py_prev = DrawY;
    end

    check("done_seen", int'(done_cyc > 0), 1);
    check("pix_total", idx, n_exp);
    if (!CLIP) check("pix_formula", idx, full_len);
    if (start_visible) check("first_lat", first_valid, 2);
    if (end_visible) check("done_lat", done_cyc - last_acc, 1);

    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      check("hold_done", draw_line_done, 1);
      check("hold_novalid", pixel_valid, 0);
    end
    draw_line_start = 1'b0;
    @(negedge Clk);
    check("done_clear", draw_line_done, 0);
    check("idle_novalid", pixel_valid, 0);
  endtask

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  initial begin
    int ax0, ay0, ax1, ay1;
    Reset_n = 1'b0; draw_line_start = 1'b0; pixel_ready = 1'b1;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    #12;
    check("rst_x", DrawX, 0);
    check("rst_y", DrawY, 0);
    check("rst_valid", pixel_valid, 0);
    check("rst_done", draw_line_done, 0);
    @(negedge Clk);
    Reset_n = 1'b1;

    run_line(0, 0, 9, 0, 0);
    run_line(5, 20, 2, 10, 0);
    run_line(100, 100, 100, 100, 0);
    run_line(0, 0, 3, 3, 2);
    run_line(639, 479, 0, 0, 1);

    // Reset in the middle of a line must abort it asynchronously.
    @(negedge Clk);
    x0 = 10'd0; y0 = 10'd0; x1 = 10'd50; y1 = 10'd20;
    draw_line_start = 1'b1;
    pixel_ready     = 1'b1;
    repeat (5) @(negedge Clk);
    check("pre_rst_valid", pixel_valid, 1);
    #2 Reset_n = 1'b0;
    #1;
    check("arst_x", DrawX, 0);
    check("arst_y", DrawY, 0);
    check("arst_valid", pixel_valid, 0);
    check("arst_done", draw_line_done, 0);
    draw_line_start = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      check("post_rst_valid", pixel_valid, 0);
      check("post_rst_done", draw_line_done, 0);
    end

    for (int t = 0; t < 30; t++) begin
      ax0 = $urandom_range(0, 639);
      ay0 = $urandom_range(0, 479);
      if (t % 5 == 0) begin
        ax1 = $urandom_range(0, 639);
        ay1 = $urandom_range(0, 479);
      end else begin
        ax1 = clampi(ax0 + $urandom_range(0, 60) - 30, 639);
        ay1 = clampi(ay0 + $urandom_range(0, 60) - 30, 479);
      end
      run_line(ax0, ay0, ax1, ay1, $urandom_range(0, 1));
    end

`ifdef DRAW_LINE_CLIP_EN
    run_line(636, 0, 643, 0, 0);
    run_line(636, 0, 643, 0, 1);
    run_line(630, 470, 660, 490, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
